// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, per-round shift counts,
// widths and the scheduler state encoding.
package des_pkg;

  localparam int KEY_W   = 64;
  localparam int HALF_W  = 28;
  localparam int RKEY_W  = 48;
  localparam int ROUND_N = 16;

  // Table entries are 1-based DES bit numbers; DES bit 1 is the MSB of the source word.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied to produce round r's C/D, indexed by r-1.
  localparam int SHIFT [ROUND_N] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when every byte of the key carries odd parity.
  function automatic logic odd_parity_ok(input logic [KEY_W-1:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < KEY_W/8; b++) begin
      if (^k[8*b +: 8] == 1'b0) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: 56-bit {C,D} to a 48-bit round key.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*HALF_W-1:0] cd,
  output logic [RKEY_W-1:0]   rkey
);

  always_comb begin
    rkey = '0;
    for (int i = 0; i < RKEY_W; i++) begin
      rkey[RKEY_W-1-i] = cd[2*HALF_W - PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES round-key scheduler: one rotate stage feeding one PC-2 stage,
// K1..K16 for encrypt or K16..K1 for decrypt. DES_KEY_PARITY_CHECK_EN adds per-byte odd-parity rejection.
module des_key_sched_ctrl
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              decrypt,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              abort,
  output logic [RKEY_W-1:0] rkey,
  output logic [3:0]        rkey_idx,
  output logic              rkey_valid,
  input  logic              rkey_ready,
  output logic              busy,
  output logic              done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic              parity_err
`endif
);

  state_t state;
  state_t next_state;

  logic [HALF_W-1:0]   c;
  logic [HALF_W-1:0]   d;
  logic [3:0]          idx;
  logic [3:0]          idx_inc;
  logic                dec;
  logic [2*HALF_W-1:0] pc1_cd;
  logic [HALF_W-1:0]   c0;
  logic [HALF_W-1:0]   d0;
  logic                key_hs;
  logic                parity_ok;
  logic                load;
  logic                last;
  logic                advance;

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 2*HALF_W; i++) begin
      pc1_cd[2*HALF_W-1-i] = key_in[KEY_W - PC1[i]];
    end
  end

  assign c0 = pc1_cd[2*HALF_W-1:HALF_W];
  assign d0 = pc1_cd[HALF_W-1:0];

`ifdef DES_KEY_PARITY_CHECK_EN
  assign parity_ok = odd_parity_ok(key_in);
`else
  assign parity_ok = 1'b1;
`endif

  assign key_hs  = key_valid & key_ready;
  assign load    = key_hs & ~abort & parity_ok;
  assign idx_inc = idx + 4'd1;
  assign last    = dec ? (idx == 4'd0) : (idx == 4'd15);
  assign advance = rkey_valid & rkey_ready & ~abort & ~last;

  // Control stage: state register; key_ready is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_ready <= 1'b0;
    end else begin
      state     <= next_state;
      key_ready <= (next_state == ST_IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (load) next_state = ST_ROUND;
      end
      ST_ROUND: begin
        if (abort)                   next_state = ST_IDLE;
        else if (rkey_ready && last) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rkey_valid = (state == ST_ROUND);
    busy       = (state == ST_ROUND) || (state == ST_DONE);
    done       = (state == ST_DONE);
  end

  // Rotate stage: C/D hold the halves for the round currently presented on rkey.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c   <= '0;
      d   <= '0;
      idx <= '0;
      dec <= 1'b0;
    end else if (load) begin
      dec <= decrypt;
      if (decrypt) begin
        c   <= c0;
        d   <= d0;
        idx <= 4'd15;
      end else begin
        c   <= rotl(c0, 1'b0);
        d   <= rotl(d0, 1'b0);
        idx <= 4'd0;
      end
    end else if (advance) begin
      if (dec) begin
        c   <= rotr(c, SHIFT[idx] == 2);
        d   <= rotr(d, SHIFT[idx] == 2);
        idx <= idx - 4'd1;
      end else begin
        c   <= rotl(c, SHIFT[idx_inc] == 2);
        d   <= rotl(d, SHIFT[idx_inc] == 2);
        idx <= idx_inc;
      end
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (key_hs && !abort) begin
      parity_err <= ~parity_ok;
    end
  end
`endif

  assign rkey_idx = idx;

  // Selection stage: PC-2 straight off the C/D registers.
  des_pc2 u_pc2 (
    .cd   ({c, d}),
    .rkey (rkey)
  );

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic        abort = 1'b0;
  logic [47:0] rkey;
  logic [3:0]  rkey_idx;
  logic        rkey_valid;
  logic        rkey_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        parity_err;
`endif

  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] rk;
  } exp_t;

  localparam logic [63:0] TEST_KEY = 64'h133457799BBCDFF1;

  logic [47:0] gold [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   hs_count = 0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_rkey = '0;
  logic [3:0]  prev_idx = '0;

  always #5 clk = ~clk;

  des_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .decrypt    (decrypt),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .abort      (abort),
    .rkey       (rkey),
    .rkey_idx   (rkey_idx),
    .rkey_valid (rkey_valid),
    .rkey_ready (rkey_ready),
    .busy       (busy),
    .done       (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Scoreboard consumer and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", rkey_valid, 1);
        check("stall_rkey", rkey, prev_rkey);
        check("stall_idx", rkey_idx, prev_idx);
      end
      if (rkey_valid && rkey_ready) begin
        hs_count++;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("rkey_idx", rkey_idx, mon_e.idx);
          check("rkey", rkey, mon_e.rk);
        end
      end
      prev_stall = rkey_valid && !rkey_ready && !abort;
      prev_rkey  = rkey;
      prev_idx   = rkey_idx;
    end
  end

  task automatic wait_key_ready();
    int n;
    n = 0;
    while (!key_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("key_ready_wait", key_ready, 1);
  endtask

  task automatic load_key(input logic [63:0] k, input logic dec, input bit expect_ok);
    int r;
    wait_key_ready();
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    if (expect_ok) begin
      for (int i = 0; i < 16; i++) begin
        r = dec ? 15 - i : i;
        sb.push_back({r[3:0], gold[r]});
      end
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = '0;
  endtask

  // Entered at cycle T+1 after the key handshake; exp_done of 0 skips the latency check.
  task automatic run_sched(input bit stall, input int exp_done, input string tag);
    int n;
    int hs0;
    bit seen;
    n    = 1;
    hs0  = hs_count;
    seen = 1'b0;
    check({tag, "_first_valid"}, rkey_valid, 1);
    check({tag, "_busy"}, busy, 1);
    while (n < 300) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) rkey_ready = ($urandom_range(0, 99) >= 30);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (exp_done > 0) check({tag, "_done_cycle"}, n, exp_done);
    check({tag, "_hs_count"}, hs_count - hs0, 16);
    check({tag, "_sb_empty"}, sb.size(), 0);
    rkey_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_key_ready_back"}, key_ready, 1);
  endtask

  task automatic run_to_idx(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (rkey_idx != target && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_reach_idx"}, rkey_idx, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rkey_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", key_ready, 0);
    check("rst_rkey", rkey, 0);
    check("rst_rkey_idx", rkey_idx, 0);
    check("rst_rkey_valid", rkey_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef DES_KEY_PARITY_CHECK_EN
    check("rst_parity_err", parity_err, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_key_ready", key_ready, 1);

    load_key(TEST_KEY, 1'b0, 1'b1);
    run_sched(1'b0, 17, "enc");

    load_key(TEST_KEY, 1'b1, 1'b1);
    run_sched(1'b0, 17, "dec");

    load_key(TEST_KEY, 1'b0, 1'b1);
    run_sched(1'b1, 0, "bp");

    // Abort while stalled on K8.
    load_key(TEST_KEY, 1'b0, 1'b1);
    run_to_idx(4'd7, "abort");
    rkey_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_stalled_idx", rkey_idx, 7);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", rkey_valid, 0);
    check("abort_key_ready", key_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    rkey_ready = 1'b1;
    load_key(TEST_KEY, 1'b0, 1'b1);
    run_sched(1'b0, 17, "post_abort");

    // Asynchronous reset during round 5.
    load_key(TEST_KEY, 1'b0, 1'b1);
    run_to_idx(4'd4, "rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_key_ready", key_ready, 0);
    check("rst_mid_rkey", rkey, 0);
    check("rst_mid_idx", rkey_idx, 0);
    check("rst_mid_valid", rkey_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_key(TEST_KEY, 1'b1, 1'b1);
    run_sched(1'b0, 17, "post_rst");

`ifdef DES_KEY_PARITY_CHECK_EN
    load_key(64'h0, 1'b0, 1'b0);
    check("par_err_set", parity_err, 1);
    check("par_no_valid", rkey_valid, 0);
    check("par_key_ready", key_ready, 1);
    @(posedge clk); #1;
    check("par_no_valid2", rkey_valid, 0);
    check("par_err_sticky", parity_err, 1);
    load_key(TEST_KEY, 1'b0, 1'b1);
    check("par_err_clear", parity_err, 0);
    run_sched(1'b0, 17, "par_ok");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
